// File: rtl/cnt_bank_ctrl_if.sv
// Bus bundle for cnt_bank_ctrl: increment request/grant handshake, load port
// and counter/overflow status. The master drives requests and loads.
interface cnt_bank_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       req;
    logic [2:0]       ack;
    logic             ld_vld;
    logic [1:0]       ld_sel;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] cnt0;
    logic [WIDTH-1:0] cnt1;
    logic [WIDTH-1:0] cnt2;
    logic [2:0]       ovf;

    modport master (
        output req, ld_vld, ld_sel, ld_data,
        input  ack, cnt0, cnt1, cnt2, ovf
    );

    modport slave (
        input  req, ld_vld, ld_sel, ld_data,
        output ack, cnt0, cnt1, cnt2, ovf
    );
endinterface

// File: rtl/cnt_bank_ctrl.sv
// Three counters sharing one incrementer behind a round-robin arbiter, with a load port.
// Build option: define CNT_BANK_SAT_EN to saturate at all-ones instead of wrapping.
module cnt_bank_ctrl #(
    parameter int          WIDTH = 16,
    parameter int unsigned INIT0 = 111,
    parameter int unsigned INIT1 = 222,
    parameter int unsigned INIT2 = 333
) (
    input  logic           clk,
    input  logic           rst,
    cnt_bank_ctrl_if.slave bus
);

    logic [WIDTH-1:0] cnt_q [3];
    logic [WIDTH-1:0] cnt_d [3];
    logic [2:0]       ovf_q, ovf_d;
    logic [2:0]       ack_q, ack_d;
    logic [1:0]       ptr_q, ptr_d;

    logic             load_hit;
    logic [3:0]       elig;
    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] inc_in;
    logic [WIDTH-1:0] inc_out;
    logic             inc_ovf;

    // Ring index arithmetic over the three requesters (operands are 0..2).
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Shared incrementer; MSB of the result flags an increment from all-ones.
    function automatic logic [WIDTH:0] bump(input logic [WIDTH-1:0] v);
`ifdef CNT_BANK_SAT_EN
        if (&v) begin
            return {1'b1, v};
        end
        return {1'b0, v + WIDTH'(1)};
`else
        return {1'b0, v} + (WIDTH + 1)'(1);
`endif
    endfunction

    // A valid load owns the cycle; ld_sel==3 is a no-op that leaves arbitration alone.
    always_comb begin
        load_hit = bus.ld_vld && (bus.ld_sel != 2'd3);
        elig     = {1'b0, bus.req & ~ack_q};
    end

    // Scan lowest to highest priority so the last hit is the winner.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = mod3_add(ptr_q, 2'(k));
            if (elig[cand]) begin
                gnt_vld = !load_hit;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        case (gnt_idx)
            2'd1:    inc_in = cnt_q[1];
            2'd2:    inc_in = cnt_q[2];
            default: inc_in = cnt_q[0];
        endcase
        {inc_ovf, inc_out} = bump(inc_in);
    end

    always_comb begin
        ack_d = 3'b000;
        ptr_d = ptr_q;
        ovf_d = ovf_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load_hit && (bus.ld_sel == 2'(i))) begin
                cnt_d[i] = bus.ld_data;
                ovf_d[i] = 1'b0;
            end else if (gnt_vld && (gnt_idx == 2'(i))) begin
                cnt_d[i] = inc_out;
                ovf_d[i] = ovf_q[i] | inc_ovf;
                ack_d[i] = 1'b1;
            end
        end
        if (gnt_vld) begin
            ptr_d = mod3_add(gnt_idx, 2'd1);
        end
    end

    // State register: reset overrides any load or grant in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q[0] <= WIDTH'(INIT0);
            cnt_q[1] <= WIDTH'(INIT1);
            cnt_q[2] <= WIDTH'(INIT2);
            ovf_q    <= 3'b000;
            ack_q    <= 3'b000;
            ptr_q    <= 2'd0;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            cnt_q[2] <= cnt_d[2];
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.ack  = ack_q;
    assign bus.ovf  = ovf_q;
    assign bus.cnt0 = cnt_q[0];
    assign bus.cnt1 = cnt_q[1];
    assign bus.cnt2 = cnt_q[2];

endmodule

// File: tb/tb_cnt_bank_ctrl.sv
// Scoreboard bench for cnt_bank_ctrl: a behavioural model predicts each cycle's
// outputs, which are queued at drive time and compared after the clock edge.
module tb_cnt_bank_ctrl;

    localparam int W = 16;
`ifdef CNT_BANK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]   ack;
        logic [2:0]   ovf;
        logic [W-1:0] c0;
        logic [W-1:0] c1;
        logic [W-1:0] c2;
    } exp_t;

    logic clk;
    logic rst;

    cnt_bank_ctrl_if #(.WIDTH(W)) bus ();

    cnt_bank_ctrl #(.WIDTH(W), .INIT0(111), .INIT1(222), .INIT2(333)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t sb_q[$];

    // Reference model state
    int unsigned m_cnt [3];
    logic [2:0]  m_ovf;
    logic [2:0]  m_ack;
    int          m_p;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        int   win;
        logic [2:0] el;
        if (rst) begin
            m_cnt[0] = 111; m_cnt[1] = 222; m_cnt[2] = 333;
            m_ovf = 3'b000; m_ack = 3'b000; m_p = 0;
            return;
        end
        if (bus.ld_vld && bus.ld_sel != 2'd3) begin
            m_cnt[bus.ld_sel] = bus.ld_data;
            m_ovf[bus.ld_sel] = 1'b0;
            m_ack = 3'b000;
            return;
        end
        el  = bus.req & ~m_ack;
        win = -1;
        for (int k = 0; k < 3; k++) begin
            if (win < 0 && el[(m_p + k) % 3]) win = (m_p + k) % 3;
        end
        m_ack = 3'b000;
        if (win >= 0) begin
            if (m_cnt[win] == 32'hFFFF) begin
                m_ovf[win] = 1'b1;
                m_cnt[win] = SAT ? 32'hFFFF : 32'h0;
            end else begin
                m_cnt[win] = m_cnt[win] + 1;
            end
            m_ack[win] = 1'b1;
            m_p = (win + 1) % 3;
        end
    endtask

    task automatic step();
        exp_t e;
        exp_t o;
        model_step();
        e.ack = m_ack;
        e.ovf = m_ovf;
        e.c0  = W'(m_cnt[0]);
        e.c1  = W'(m_cnt[1]);
        e.c2  = W'(m_cnt[2]);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb_q.pop_front();
            chk("ack",  {29'd0, bus.ack}, {29'd0, o.ack});
            chk("ovf",  {29'd0, bus.ovf}, {29'd0, o.ovf});
            chk("cnt0", {16'd0, bus.cnt0}, {16'd0, o.c0});
            chk("cnt1", {16'd0, bus.cnt1}, {16'd0, o.c1});
            chk("cnt2", {16'd0, bus.cnt2}, {16'd0, o.c2});
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] rq, input logic lv,
                         input logic [1:0] ls, input logic [W-1:0] ld);
        rst         = r;
        bus.req     = rq;
        bus.ld_vld  = lv;
        bus.ld_sel  = ls;
        bus.ld_data = ld;
    endtask

    logic [2:0]   rr_seq [6];
    logic [W-1:0] c0_before;
    logic [W-1:0] rdata;

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
        m_ovf = 3'b000; m_ack = 3'b000; m_p = 0;
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;

        // Reset with all requests pending
        drive(1'b1, 3'b111, 1'b1, 2'd0, 16'h1234);
        step();
        chk("rst_ack",  {29'd0, bus.ack}, 32'd0);
        chk("rst_cnt0", {16'd0, bus.cnt0}, 32'd111);
        chk("rst_cnt1", {16'd0, bus.cnt1}, 32'd222);
        chk("rst_cnt2", {16'd0, bus.cnt2}, 32'd333);
        chk("rst_ovf",  {29'd0, bus.ovf}, 32'd0);

        // Round-robin with all three requesting
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'b111, 1'b0, 2'd0, 16'h0);
            step();
            chk("rr_order", {29'd0, bus.ack}, {29'd0, rr_seq[i]});
        end
        chk("rr_cnt0", {16'd0, bus.cnt0}, 32'd113);
        chk("rr_cnt1", {16'd0, bus.cnt1}, 32'd224);
        chk("rr_cnt2", {16'd0, bus.cnt2}, 32'd335);

        drive(1'b0, 3'b000, 1'b0, 2'd0, 16'h0);
        step();

        // Load stalls arbitration, then the next grant overflows cnt1
        drive(1'b0, 3'b010, 1'b1, 2'd1, 16'hFFFF);
        step();
        chk("ld_ack",  {29'd0, bus.ack}, 32'd0);
        chk("ld_cnt1", {16'd0, bus.cnt1}, 32'h0000FFFF);
        drive(1'b0, 3'b010, 1'b0, 2'd0, 16'h0);
        step();
        chk("ovf_ack",  {29'd0, bus.ack}, 32'b010);
        chk("ovf_cnt1", {16'd0, bus.cnt1}, SAT ? 32'h0000FFFF : 32'h0);
        chk("ovf_flag", {29'd0, bus.ovf}, 32'b010);

        // ld_sel=3 is a no-op and does not stall
        c0_before = bus.cnt0;
        drive(1'b0, 3'b001, 1'b1, 2'd3, 16'h5555);
        step();
        chk("nop_ack",  {29'd0, bus.ack}, 32'b001);
        chk("nop_cnt0", {16'd0, bus.cnt0}, {16'd0, c0_before + 16'd1});
        chk("nop_ovf",  {29'd0, bus.ovf}, 32'b010);

        // Randomised traffic with loads near the wrap point and occasional reset
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0:       rdata = 16'hFFFF;
                1:       rdata = 16'hFFFE;
                default: rdata = W'($urandom);
            endcase
            drive(($urandom_range(0, 59) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), rdata);
            step();
        end

        // Reset while all requests are pending, then restart from index 0
        drive(1'b1, 3'b111, 1'b0, 2'd0, 16'h0);
        step();
        chk("rst2_ack",  {29'd0, bus.ack}, 32'd0);
        chk("rst2_cnt2", {16'd0, bus.cnt2}, 32'd333);
        drive(1'b0, 3'b111, 1'b0, 2'd0, 16'h0);
        step();
        chk("rst2_first", {29'd0, bus.ack}, 32'b001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cnt_bank_ctrl.md
CNT_BANK_CTRL -- requirements
Module: cnt_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: width of every counter and of ld_data.
REQ-002 Parameter INIT0, default 111: reset value of cnt0.
REQ-003 Parameter INIT1, default 222: reset value of cnt1.
REQ-004 Parameter INIT2, default 333: reset value of cnt2.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  3  per-requester increment request; bit i targets cnt i.
REQ-008 ack  out  3  registered one-hot grant pulse; bit i acknowledges req[i].
REQ-009 ld_vld  in  1  load strobe.
REQ-010 ld_sel  in  2  load target index; 0..2 valid, 3 = no-op.
REQ-011 ld_data  in  WIDTH  load value.
REQ-012 cnt0, cnt1, cnt2  out  WIDTH  registered counter values.
REQ-013 ovf  out  3  sticky overflow flag per counter.

Function
REQ-014 The block SHALL contain one shared incrementer used by at most one counter per cycle.
REQ-015 Eligible set per cycle SHALL be req & ~ack; a requester whose ack is high SHALL NOT be granted that cycle.
REQ-016 Arbitration SHALL be round-robin: a 2-bit pointer p (0..2) gives highest priority to index p, then p+1, then p+2 (mod 3).
REQ-017 On grant to i at edge k: cnt i SHALL become cnt i + 1, ack[i] SHALL be 1 and other ack bits 0 after edge k, and p SHALL become (i+1) mod 3.
REQ-018 With no eligible requester and no stalling load: ack SHALL be 0 after the edge and p SHALL be unchanged.
REQ-019 ack SHALL be high exactly one cycle per grant; latency from eligible req to ack is one cycle when uncontended.
REQ-020 Requester protocol: hold req until ack is seen; dropping req before ack withdraws the request without error.
REQ-021 ld_vld=1 with ld_sel in 0..2 SHALL load ld_data into cnt ld_sel, clear ovf[ld_sel], and stall arbitration that cycle (no grant, ack=0 next cycle, p unchanged).
REQ-022 ld_vld=1 with ld_sel=3 SHALL change nothing and SHALL NOT stall arbitration.
REQ-023 Increment of a counter at 2^WIDTH-1 SHALL wrap to 0 and set ovf[i]; ovf[i] stays set until load to i or reset.
REQ-024 cnt and ovf SHALL change only via grant, load or reset.

Reset
REQ-025 rst=1 at an edge SHALL set cnt0=INIT0, cnt1=INIT1, cnt2=INIT2, ack=0, ovf=0, p=0, overriding loads and requests.
REQ-026 Requests pending at reset SHALL be dropped without ack; requesters re-arbitrate from p=0 after rst falls.

Configuration
REQ-027 Macro CNT_BANK_SAT_EN: when defined, an increment at 2^WIDTH-1 SHALL hold the counter at 2^WIDTH-1, set ovf[i], and still issue ack[i].
REQ-028 Without CNT_BANK_SAT_EN, wrap-around per REQ-023 SHALL apply.

Verification
REQ-029 Reset: rst=1 one edge -> cnt0=111, cnt1=222, cnt2=333, ack=000, ovf=000.
REQ-030 req=111 held 6 cycles after reset -> acks in order 001,010,100,001,010,100 (one-cycle gaps per REQ-015 masking); each counter +2.
REQ-031 Load: ld_vld=1, ld_sel=1, ld_data=0xFFFF with req=010 -> no ack that cycle, cnt1=0xFFFF; next grant -> cnt1=0x0000, ovf=010 (with CNT_BANK_SAT_EN: cnt1=0xFFFF, ovf=010).
REQ-032 ld_sel=3 with req=001 -> ack=001 next cycle, cnt0=112, no other change.
REQ-033 rst asserted while req=111 pending -> no ack after reset edge, counters at INIT values, first post-reset grant to index 0.
